// File: rtl/read_data_return.sv
// Pairs read-data FIFO words with in-order request IDs and returns {id,data}.
// Optional `RESP_PARITY_EN adds o_resp_parity registered alongside the data.
`ifndef BACKEND_WORD_SIZE
`define BACKEND_WORD_SIZE 32
`endif

module read_data_return #(
  parameter int DATA_WIDTH = `BACKEND_WORD_SIZE,
  parameter int ID_WIDTH   = 4,
  parameter int TAG_DEPTH  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  input  logic [ID_WIDTH-1:0]   i_req_id,
  output logic                  o_tag_full,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [ID_WIDTH-1:0]   o_resp_id,
  output logic [DATA_WIDTH-1:0] o_resp_data,
`ifdef RESP_PARITY_EN
  output logic                  o_resp_parity,
`endif
  output logic [TAG_DEPTH:0]    o_outstanding,
  output logic [1:0]            o_err
);

  localparam int TAGS = 1 << TAG_DEPTH;
  localparam logic [TAG_DEPTH:0] FULL_PAT = {1'b1, {TAG_DEPTH{1'b0}}};

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } state_e;

  state_e state_q, state_d;

  logic [ID_WIDTH-1:0]   tag_mem_q [TAGS];
  logic [TAG_DEPTH:0]    wr_ptr_q, wr_ptr_d;
  logic [TAG_DEPTH:0]    rd_ptr_q, rd_ptr_d;
  logic [TAG_DEPTH:0]    cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic [1:0]            err_q, err_d;
  logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  tag_avail;
  logic                  push;
  logic                  pop;

  always_comb begin
    // Count is registered, so a tag pushed this cycle is poppable next cycle.
    tag_avail = (cnt_q != '0);
    push      = i_req_valid && !full_q;
    pop       = i_rst_n && !i_fifo_empty && tag_avail &&
                ((state_q == S_EMPTY) || i_resp_ready);

    wr_ptr_d = wr_ptr_q + {{TAG_DEPTH{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{TAG_DEPTH{1'b0}}, pop};
    cnt_d    = wr_ptr_d - rd_ptr_d;
    full_d   = ((wr_ptr_d ^ rd_ptr_d) == FULL_PAT);

    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (pop) state_d = S_FULL;
      S_FULL:  if (i_resp_ready && !pop) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase

    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    if (pop) begin
      resp_id_d   = tag_mem_q[rd_ptr_q[TAG_DEPTH-1:0]];
      resp_data_d = i_fifo_data;
    end

    err_d    = err_q;
    err_d[0] = err_q[0] | (i_req_valid && full_q);
    err_d[1] = err_q[1] |
               (!i_fifo_empty && !tag_avail && (state_d == state_q));
  end

  always_ff @(posedge i_clk) begin
    if (push) tag_mem_q[wr_ptr_q[TAG_DEPTH-1:0]] <= i_req_id;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      err_q       <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      err_q       <= err_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
    end
  end

`ifdef RESP_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (pop) par_d = ^i_fifo_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) par_q <= 1'b0;
    else          par_q <= par_d;
  end

  assign o_resp_parity = par_q;
`endif

  assign o_tag_full    = full_q;
  assign o_fifo_rd_en  = pop;
  assign o_resp_valid  = (state_q == S_FULL);
  assign o_resp_id     = resp_id_q;
  assign o_resp_data   = resp_data_q;
  assign o_outstanding = cnt_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_read_data_return.sv
// Directed bench for read_data_return: reset, ordering, full, hold, overlap.
// Build with RESP_PARITY_EN defined to also check o_resp_parity.
module tb_read_data_return;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int TD = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic [IW-1:0] req_id;
  logic          tag_full;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          resp_valid;
  logic          resp_ready;
  logic [IW-1:0] resp_id;
  logic [DW-1:0] resp_data;
  logic [TD:0]   outstanding;
  logic [1:0]    err;
`ifdef RESP_PARITY_EN
  logic          resp_parity;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  read_data_return #(
    .DATA_WIDTH(DW),
    .ID_WIDTH(IW),
    .TAG_DEPTH(TD)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req_valid(req_valid),
    .i_req_id(req_id),
    .o_tag_full(tag_full),
    .i_fifo_data(fifo_data),
    .i_fifo_empty(fifo_empty),
    .o_fifo_rd_en(fifo_rd_en),
    .o_resp_valid(resp_valid),
    .i_resp_ready(resp_ready),
    .o_resp_id(resp_id),
    .o_resp_data(resp_data),
`ifdef RESP_PARITY_EN
    .o_resp_parity(resp_parity),
`endif
    .o_outstanding(outstanding),
    .o_err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic empty);
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_id     = '0;
    fifo_data  = '0;
    fifo_empty = empty;
    resp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_resp(input string tag, input logic v,
                          input logic [IW-1:0] id, input logic [DW-1:0] d);
    chk({tag, "_valid"}, 32'(resp_valid), 32'(v));
    chk({tag, "_id"}, 32'(resp_id), 32'(id));
    chk({tag, "_data"}, 32'(resp_data), 32'(d));
  endtask

  initial begin
    // Reset with FIFO non-empty but no tags.
    do_reset(1'b0);
    rst_n = 1'b0;
    #1;
    chk_resp("rst", 1'b0, 4'h0, 8'h00);
    chk("rst_full", 32'(tag_full), 0);
    chk("rst_outst", 32'(outstanding), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rden", 32'(fifo_rd_en), 0);
    rst_n = 1'b1;
    #1;
    chk("idle_rden", 32'(fifo_rd_en), 0);
    tick();
    chk("idle_err1", 32'(err), 32'h2);
    chk("idle_valid", 32'(resp_valid), 0);

    // IDs 3,5 paired with 0xA,0xB back to back.
    do_reset(1'b1);
    req_valid = 1'b1;
    req_id    = 4'd3;
    tick();
    req_id = 4'd5;
    tick();
    req_valid = 1'b0;
    chk("pair_outst2", 32'(outstanding), 2);
    fifo_empty = 1'b0;
    fifo_data  = 8'h0A;
    resp_ready = 1'b1;
    #1;
    chk("pair_rden0", 32'(fifo_rd_en), 1);
    tick();
    chk_resp("pair0", 1'b1, 4'd3, 8'h0A);
    chk("pair_outst1", 32'(outstanding), 1);
    fifo_data = 8'h0B;
    #1;
    chk("pair_rden1", 32'(fifo_rd_en), 1);
    tick();
    chk_resp("pair1", 1'b1, 4'd5, 8'h0B);
    chk("pair_outst0", 32'(outstanding), 0);
    fifo_empty = 1'b1;
    tick();
    chk("pair_done", 32'(resp_valid), 0);
    chk("pair_err", 32'(err), 0);

    // Fill all 8 tags, then a dropped 9th push.
    do_reset(1'b1);
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_id = IW'(i);
      chk($sformatf("fill_nf%0d", i), 32'(tag_full), 0);
      tick();
    end
    chk("fill_full", 32'(tag_full), 1);
    chk("fill_outst8", 32'(outstanding), 8);
    req_id = 4'd9;
    tick();
    req_valid = 1'b0;
    chk("fill_err0", 32'(err), 32'h1);
    chk("fill_outst_keep", 32'(outstanding), 8);

    // Hold with ready low: one pop, then stable for 4 cycles.
    fifo_empty = 1'b0;
    fifo_data  = 8'h11;
    resp_ready = 1'b0;
    tick();
    chk_resp("hold_first", 1'b1, 4'd0, 8'h11);
    chk("hold_outst7", 32'(outstanding), 7);
    chk("hold_notfull", 32'(tag_full), 0);
    fifo_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold_rden%0d", i), 32'(fifo_rd_en), 0);
      tick();
      chk_resp($sformatf("hold%0d", i), 1'b1, 4'd0, 8'h11);
    end
    resp_ready = 1'b1;
    #1;
    chk("hold_release", 32'(fifo_rd_en), 1);
    tick();
    chk_resp("hold_next", 1'b1, 4'd1, 8'h22);
    chk("hold_outst6", 32'(outstanding), 6);

    // Push and pop in the same cycle with 2 outstanding.
    do_reset(1'b1);
    req_valid = 1'b1;
    req_id    = 4'd1;
    tick();
    req_id = 4'd2;
    tick();
    chk("ovl_outst2", 32'(outstanding), 2);
    req_id     = 4'd4;
    fifo_empty = 1'b0;
    fifo_data  = 8'h07;
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("ovl_outst_same", 32'(outstanding), 2);
    chk_resp("ovl0", 1'b1, 4'd1, 8'h07);
`ifdef RESP_PARITY_EN
    chk("par_07", 32'(resp_parity), 1);
`endif
    fifo_data = 8'h03;
    tick();
    chk_resp("ovl1", 1'b1, 4'd2, 8'h03);
    chk("ovl_outst1", 32'(outstanding), 1);
`ifdef RESP_PARITY_EN
    chk("par_03", 32'(resp_parity), 0);
`endif
    fifo_data = 8'h55;
    tick();
    fifo_empty = 1'b1;
    chk_resp("ovl2", 1'b1, 4'd4, 8'h55);
    chk("ovl_outst0", 32'(outstanding), 0);
    tick();
    chk("ovl_done", 32'(resp_valid), 0);
    chk("ovl_err", 32'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
